// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and qualify four push-buttons into one clean press.
// Optional feature macro BTN_PULSE_EN adds a one-cycle btn_pulse on each accepted press.
module button_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk_tick,
    input  logic       reset_n,
    input  logic [3:0] btn_raw,
    output logic       btn_valid,
    output logic [1:0] btn_val,
    output logic       multi_err,
    output logic [3:0] db_btn,
    output logic [1:0] btn_state,
    output logic [7:0] press_cnt
`ifdef BTN_PULSE_EN
    ,
    output logic       btn_pulse
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, LOCK = 2'd2} state_t;

    logic [3:0]       r_sync1, r_sync2, r_db;
    logic [CNT_W-1:0] r_cnt [4];
    state_t           r_state, w_state;
    logic             r_valid, w_valid, r_err, w_err, w_take;
    logic [1:0]       r_val, w_val, w_idx;
    logic [7:0]       r_press, w_press;

    // two-flop synchroniser per button, raw inputs are asynchronous
    always_ff @(posedge clk_tick or negedge reset_n)
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end

    // per-button debounce: flip only after DB_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk_tick or negedge reset_n)
        if (!reset_n) begin
            r_db <= '0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (r_sync2[k] == r_db[k])
                    r_cnt[k] <= '0;
                else if (r_cnt[k] == CNT_W'(DB_CYCLES - 1)) begin
                    r_db[k]  <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else
                    r_cnt[k] <= r_cnt[k] + 1'b1;
        end

    // index of the set bit, only meaningful when r_db is one-hot
    assign w_idx = {r_db[2] | r_db[3], r_db[1] | r_db[3]};

    // press qualification: next state and next registered outputs
    always_comb begin
        w_state = r_state;
        w_valid = r_valid;
        w_err   = r_err;
        w_val   = r_val;
        w_press = r_press;
        w_take  = 1'b0;
        case (r_state)
            IDLE: begin
                w_valid = 1'b0;
                w_err   = 1'b0;
                if ($onehot(r_db)) begin
                    w_state = HELD;
                    w_val   = w_idx;
                    w_valid = 1'b1;
                    w_press = r_press + 8'd1;
                    w_take  = 1'b1;
                end else if (|r_db) begin
                    w_state = LOCK;
                    w_err   = 1'b1;
                end
            end
            HELD: begin
                if (r_db == 4'd0) begin
                    w_state = IDLE;
                    w_valid = 1'b0;
                end else if (r_db != (4'b0001 << r_val)) begin
                    w_state = LOCK;
                    w_valid = 1'b0;
                    w_err   = 1'b1;
                end
            end
            LOCK: begin
                w_valid = 1'b0;
                if (r_db == 4'd0) begin
                    w_state = IDLE;
                    w_err   = 1'b0;
                end
            end
            default: begin
                w_state = IDLE;
                w_valid = 1'b0;
                w_err   = 1'b0;
            end
        endcase
    end

    // state and registered output update
    always_ff @(posedge clk_tick or negedge reset_n)
        if (!reset_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_val   <= 2'd0;
            r_press <= 8'd0;
        end else begin
            r_state <= w_state;
            r_valid <= w_valid;
            r_err   <= w_err;
            r_val   <= w_val;
            r_press <= w_press;
        end

`ifdef BTN_PULSE_EN
    logic r_pulse;

    // one-cycle strobe aligned with the first btn_valid cycle of a press
    always_ff @(posedge clk_tick or negedge reset_n)
        if (!reset_n) r_pulse <= 1'b0;
        else          r_pulse <= w_take;

    assign btn_pulse = r_pulse;
`endif

    assign btn_valid = r_valid;
    assign btn_val   = r_val;
    assign multi_err = r_err;
    assign db_btn    = r_db;
    assign btn_state = r_state;
    assign press_cnt = r_press;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed stimulus against a behavioural press model.
module tb_button_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] btn_raw;
    logic       btn_valid, multi_err;
    logic [1:0] btn_val, btn_state;
    logic [3:0] db_btn;
    logic [7:0] press_cnt;
`ifdef BTN_PULSE_EN
    logic       btn_pulse;
`endif

    button_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
        .clk_tick (clk),
        .reset_n  (reset_n),
        .btn_raw  (btn_raw),
        .btn_valid(btn_valid),
        .btn_val  (btn_val),
        .multi_err(multi_err),
        .db_btn   (db_btn),
        .btn_state(btn_state),
        .press_cnt(press_cnt)
`ifdef BTN_PULSE_EN
        ,
        .btn_pulse(btn_pulse)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // behavioural model: raw samples delayed two edges, a button counts as
    // changed once its last DB delayed samples all disagree with it
    logic [3:0] q_raw [$];
    logic [3:0] q_use [$];
    logic [3:0] m_db;
    int         m_mode;
    logic       m_valid, m_err, m_pulse;
    logic [1:0] m_val;
    logic [7:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_raw.delete();
        q_raw.push_back(4'd0);
        q_raw.push_back(4'd0);
        q_use.delete();
        m_db = 4'd0; m_mode = 0; m_valid = 1'b0; m_err = 1'b0;
        m_pulse = 1'b0; m_val = 2'd0; m_cnt = 8'd0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] u;
        int n;
        bit all_diff;
        n = $countones(m_db);
        m_pulse = 1'b0;
        if (m_mode == 0) begin
            if (n == 1) begin
                m_mode = 1; m_valid = 1'b1; m_cnt = m_cnt + 8'd1; m_pulse = 1'b1;
                for (int b = 0; b < 4; b++) if (m_db[b]) m_val = 2'(b);
            end else if (n > 1) begin
                m_mode = 2; m_err = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (n == 0) begin
                m_mode = 0; m_valid = 1'b0;
            end else if (m_db != (4'b0001 << m_val)) begin
                m_mode = 2; m_valid = 1'b0; m_err = 1'b1;
            end
        end else if (n == 0) begin
            m_mode = 0; m_err = 1'b0;
        end
        u = q_raw.pop_front();
        q_raw.push_back(raw);
        q_use.push_back(u);
        if (q_use.size() > DB) void'(q_use.pop_front());
        if (q_use.size() == DB)
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                foreach (q_use[j]) if (q_use[j][b] == m_db[b]) all_diff = 1'b0;
                if (all_diff) m_db[b] = ~m_db[b];
            end
    endtask

    // one clock: advance the model at the edge, compare all outputs at the falling edge
    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge(btn_raw);
        @(negedge clk);
        chk("db_btn", 32'(db_btn), 32'(m_db));
        chk("btn_valid", 32'(btn_valid), 32'(m_valid));
        chk("btn_val", 32'(btn_val), 32'(m_val));
        chk("multi_err", 32'(multi_err), 32'(m_err));
        chk("btn_state", 32'(btn_state), 32'(m_mode));
        chk("press_cnt", 32'(press_cnt), 32'(m_cnt));
`ifdef BTN_PULSE_EN
        chk("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
`endif
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int r, rises, pulses;
        bit seen, prev;
        reset_n = 1'b0;
        btn_raw = 4'd0;
        run(3);
        reset_n = 1'b1;
        chk("rst_valid", 32'(btn_valid), 0);
        chk("rst_state", 32'(btn_state), 0);
        chk("rst_cnt", 32'(press_cnt), 0);
        chk("rst_db", 32'(db_btn), 0);

        // clean press on colour 2
        btn_raw = 4'b0100;
        run(5);
        chk("t1_db_at5", 32'(db_btn[2]), 0);
        run(1);
        chk("t1_db_at6", 32'(db_btn[2]), 1);
        chk("t1_valid_at6", 32'(btn_valid), 0);
        run(1);
        chk("t1_valid_at7", 32'(btn_valid), 1);
        chk("t1_val", 32'(btn_val), 2);
        chk("t1_cnt", 32'(press_cnt), 1);
        btn_raw = 4'd0;
        run(10);
        chk("t1_release", 32'(btn_state), 0);

        // bouncing colour 0
        btn_raw = 4'b0001; run(1);
        btn_raw = 4'b0000; run(1);
        btn_raw = 4'b0001; run(1);
        btn_raw = 4'b0000; run(1);
        btn_raw = 4'b0001; run(5);
        chk("bounce_db_at9", 32'(db_btn[0]), 0);
        run(1);
        chk("bounce_db_at10", 32'(db_btn[0]), 1);
        run(1);
        chk("bounce_valid", 32'(btn_valid), 1);
        chk("bounce_val", 32'(btn_val), 0);
        run(10);
        chk("bounce_cnt", 32'(press_cnt), 2);
        btn_raw = 4'd0;
        run(10);

        // multi-press lockout
        btn_raw = 4'b0001; run(10);
        chk("multi_first", 32'(btn_valid), 1);
        btn_raw = 4'b1001; run(10);
        chk("multi_valid", 32'(btn_valid), 0);
        chk("multi_err", 32'(multi_err), 1);
        chk("multi_val", 32'(btn_val), 0);
        btn_raw = 4'b1000; run(10);
        chk("multi_single_lock", 32'(btn_state), 2);
        chk("multi_single_valid", 32'(btn_valid), 0);
        btn_raw = 4'd0; run(10);
        chk("multi_exit_err", 32'(multi_err), 0);
        chk("multi_exit_state", 32'(btn_state), 0);
        chk("multi_exit_cnt", 32'(press_cnt), 3);

        // single-cycle glitch
        btn_raw = 4'b0010; run(1);
        btn_raw = 4'd0;
        seen = 1'b0;
        repeat (12) begin
            step();
            seen = seen | btn_valid | (db_btn != 4'd0);
        end
        chk("glitch_quiet", 32'(seen), 0);
        chk("glitch_cnt", 32'(press_cnt), 3);

        // asynchronous reset while a press is held
        btn_raw = 4'b0100; run(10);
        chk("areset_held", 32'(btn_state), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valid", 32'(btn_valid), 0);
        chk("areset_cnt", 32'(press_cnt), 0);
        chk("areset_state", 32'(btn_state), 0);
        run(2);
        reset_n = 1'b1;
        run(6);
        chk("areset_wait6", 32'(btn_valid), 0);
        run(1);
        chk("areset_reaccept", 32'(btn_valid), 1);
        chk("areset_cnt1", 32'(press_cnt), 1);
        btn_raw = 4'd0; run(10);

        // random stimulus, mostly clean single presses with bursts of noise
        repeat (150) begin
            r = $urandom_range(0, 3);
            btn_raw = (r == 0) ? 4'd0 : (r == 1) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            run($urandom_range(1, 12));
        end
        btn_raw = 4'd0;
        run(10);

        // 256 clean presses from reset wrap the press counter
        reset_n = 1'b0;
        run(2);
        reset_n = 1'b1;
        rises = 0; pulses = 0; prev = 1'b0;
        repeat (256) begin
            btn_raw = 4'(4'b0001 << $urandom_range(0, 3));
            repeat (16) begin
                if (btn_raw != 4'd0 && rises >= 0) begin end
                step();
                if (btn_valid && !prev) rises++;
                prev = btn_valid;
`ifdef BTN_PULSE_EN
                if (btn_pulse) pulses++;
`endif
                if (btn_valid) btn_raw = btn_raw;
            end
            btn_raw = 4'd0;
            run(8);
        end
        chk("wrap_cnt", 32'(press_cnt), 0);
        chk("wrap_rises", 32'(rises), 256);
`ifdef BTN_PULSE_EN
        chk("wrap_pulses", 32'(pulses), 256);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
